// File: rtl/icache_fill_unit.sv
// icache_fill_unit
//   Instruction-cache refill engine. It accepts one miss at a time and issues
//   a line-aligned read to memory. The 16 returned beats are written into the
//   icache data store one word at a time. The tag and the valid bit are
//   committed only together with the final beat, so a partially filled line
//   is never seen as valid.
//
//   Ports
//     clk, rst            : clock, asynchronous active-high reset
//     miss_*              : miss request from the icache management unit
//     abort               : cancel the current fill (flush / redirect)
//     mem_req_*           : line read request to the memory side
//     mem_resp_*          : returned beats, in order, no back-pressure
//     ic_*                : word / tag write port of the icache array
//     busy, fill_done     : status; fill_done pulses once per committed line
//
//   state | meaning
//   IDLE  | waiting for a miss, miss_ready high
//   REQ   | line read request presented to memory
//   FILL  | writing returned beats into the data store
//   DRAIN | fill aborted, swallowing the remaining beats without writing
//   DONE  | last beat and tag written, fill_done pulses on exit
module icache_fill_unit #(
  parameter int LINE_BYTES = 64,
  parameter int WORD_BYTES = 4,
  parameter int TAG_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_valid,
  output logic             miss_ready,
  input  logic [31:0]      miss_va,
  input  logic [TAG_W-1:0] miss_ptag,
  input  logic             abort,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_data,
  output logic             ic_write_enable,
  output logic [31:0]      ic_va,
  output logic [31:0]      ic_write_data,
  output logic             ic_valid_data,
  output logic             ic_dirty_data,
  output logic             ic_tag_write_enable,
  output logic [TAG_W-1:0] ic_physical_tag,
  output logic             busy,
  output logic             fill_done
);

  localparam int         BEATS     = LINE_BYTES / WORD_BYTES;
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FILL  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [3:0]       beat_q;
  logic [1:0]       idx_q;
  logic             miss_ready_q;
  logic             mem_req_valid_q;
  logic [31:0]      mem_req_addr_q;
  logic             ic_write_enable_q;
  logic [31:0]      ic_va_q;
  logic [31:0]      ic_write_data_q;
  logic             ic_valid_data_q;
  logic             ic_tag_write_enable_q;
  logic [TAG_W-1:0] ic_physical_tag_q;
  logic             busy_q;
  logic             fill_done_q;

  // Only the index bits of the virtual address matter here.
  logic unused_va_bits;
  assign unused_va_bits = ^{miss_va[31:8], miss_va[5:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q               <= IDLE;
      beat_q                <= '0;
      idx_q                 <= '0;
      miss_ready_q          <= 1'b1;
      mem_req_valid_q       <= 1'b0;
      mem_req_addr_q        <= '0;
      ic_write_enable_q     <= 1'b0;
      ic_va_q               <= '0;
      ic_write_data_q       <= '0;
      ic_valid_data_q       <= 1'b0;
      ic_tag_write_enable_q <= 1'b0;
      ic_physical_tag_q     <= '0;
      busy_q                <= 1'b0;
      fill_done_q           <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      ic_write_enable_q     <= 1'b0;
      ic_valid_data_q       <= 1'b0;
      ic_tag_write_enable_q <= 1'b0;
      fill_done_q           <= 1'b0;

      case (state_q)
        IDLE: begin
          if (miss_valid) begin
            idx_q             <= miss_va[7:6];
            ic_physical_tag_q <= miss_ptag;
            mem_req_addr_q    <= {miss_ptag, miss_va[7:6], 6'b0};
            mem_req_valid_q   <= 1'b1;
            miss_ready_q      <= 1'b0;
            busy_q            <= 1'b1;
            state_q           <= REQ;
          end
        end

        REQ: begin
          // A handshake in the abort cycle still counts as issued, so the
          // returning beats have to be drained.
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            beat_q          <= '0;
            state_q         <= abort ? DRAIN : FILL;
          end else if (abort) begin
            mem_req_valid_q <= 1'b0;
            miss_ready_q    <= 1'b1;
            busy_q          <= 1'b0;
            state_q         <= IDLE;
          end
        end

        FILL: begin
          if (abort) begin
            // A beat coinciding with abort is consumed but not written.
            if (mem_resp_valid && beat_q == LAST_BEAT) begin
              beat_q       <= '0;
              miss_ready_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              if (mem_resp_valid) beat_q <= beat_q + 4'd1;
              state_q <= DRAIN;
            end
          end else if (mem_resp_valid) begin
            ic_write_enable_q <= 1'b1;
            ic_write_data_q   <= mem_resp_data;
            ic_va_q           <= {24'b0, idx_q, beat_q, 2'b00};
            if (beat_q == LAST_BEAT) begin
              ic_valid_data_q       <= 1'b1;
              ic_tag_write_enable_q <= 1'b1;
              beat_q                <= '0;
              state_q               <= DONE;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end

        DRAIN: begin
          if (mem_resp_valid) begin
            if (beat_q == LAST_BEAT) begin
              beat_q       <= '0;
              miss_ready_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end

        DONE: begin
          fill_done_q  <= 1'b1;
          miss_ready_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end

        default: begin
          state_q      <= IDLE;
          miss_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign miss_ready          = miss_ready_q;
  assign mem_req_valid       = mem_req_valid_q;
  assign mem_req_addr        = mem_req_addr_q;
  assign ic_write_enable     = ic_write_enable_q;
  assign ic_va               = ic_va_q;
  assign ic_write_data       = ic_write_data_q;
  assign ic_valid_data       = ic_valid_data_q;
  assign ic_dirty_data       = 1'b0;
  assign ic_tag_write_enable = ic_tag_write_enable_q;
  assign ic_physical_tag     = ic_physical_tag_q;
  assign busy                = busy_q;
  assign fill_done           = fill_done_q;

endmodule

// File: tb/tb_icache_fill_unit.sv
// Directed bench for icache_fill_unit: basic fill, gapped beats, abort in
// REQ, abort mid-fill, abort on the last beat, abort in DONE, reset mid-fill.
module tb_icache_fill_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic        miss_ready;
  logic [31:0] miss_va;
  logic [23:0] miss_ptag;
  logic        abort;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        ic_write_enable;
  logic [31:0] ic_va;
  logic [31:0] ic_write_data;
  logic        ic_valid_data;
  logic        ic_dirty_data;
  logic        ic_tag_write_enable;
  logic [23:0] ic_physical_tag;
  logic        busy;
  logic        fill_done;

  int checks   = 0;
  int failures = 0;

  // Write log captured by the monitor.
  logic [31:0] wr_va   [0:31];
  logic [31:0] wr_data [0:31];
  logic        wr_vld  [0:31];
  int wr_cnt   = 0;
  int tag_cnt  = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;

  icache_fill_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .miss_valid          (miss_valid),
    .miss_ready          (miss_ready),
    .miss_va             (miss_va),
    .miss_ptag           (miss_ptag),
    .abort               (abort),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_addr        (mem_req_addr),
    .mem_resp_valid      (mem_resp_valid),
    .mem_resp_data       (mem_resp_data),
    .ic_write_enable     (ic_write_enable),
    .ic_va               (ic_va),
    .ic_write_data       (ic_write_data),
    .ic_valid_data       (ic_valid_data),
    .ic_dirty_data       (ic_dirty_data),
    .ic_tag_write_enable (ic_tag_write_enable),
    .ic_physical_tag     (ic_physical_tag),
    .busy                (busy),
    .fill_done           (fill_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (ic_write_enable) begin
        if (wr_cnt < 32) begin
          wr_va[wr_cnt]   = ic_va;
          wr_data[wr_cnt] = ic_write_data;
          wr_vld[wr_cnt]  = ic_valid_data;
        end
        wr_cnt = wr_cnt + 1;
      end
      if (ic_tag_write_enable) tag_cnt = tag_cnt + 1;
      if (fill_done) done_cnt = done_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) hs_cnt = hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_log();
    wr_cnt   = 0;
    tag_cnt  = 0;
    done_cnt = 0;
    hs_cnt   = 0;
  endtask

  task automatic issue_miss(input logic [31:0] va, input logic [23:0] ptag);
    miss_valid = 1'b1;
    miss_va    = va;
    miss_ptag  = ptag;
    step();
    miss_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] data);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    step();
    mem_resp_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] base_va,
                              input logic [31:0] base_data, input logic last_valid);
    for (int i = 0; i < n; i++) begin
      check({tag, "_va"},   wr_va[i],   base_va + 32'(4 * i));
      check({tag, "_data"}, wr_data[i], base_data + 32'(i));
      check({tag, "_vld"},  {31'b0, wr_vld[i]}, {31'b0, (last_valid && i == 15)});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_miss_ready"}, {31'b0, miss_ready}, 32'd1);
    check({tag, "_busy"},       {31'b0, busy},       32'd0);
    check({tag, "_req_valid"},  {31'b0, mem_req_valid}, 32'd0);
    check({tag, "_we"},         {31'b0, ic_write_enable}, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    miss_valid     = 1'b0;
    miss_va        = '0;
    miss_ptag      = '0;
    abort          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    step();
    step();

    // Reset values
    check("rst_miss_ready", {31'b0, miss_ready}, 32'd1);
    check("rst_req_valid",  {31'b0, mem_req_valid}, 32'd0);
    check("rst_req_addr",   mem_req_addr, 32'd0);
    check("rst_we",         {31'b0, ic_write_enable}, 32'd0);
    check("rst_va",         ic_va, 32'd0);
    check("rst_wdata",      ic_write_data, 32'd0);
    check("rst_tag_we",     {31'b0, ic_tag_write_enable}, 32'd0);
    check("rst_ptag",       {8'b0, ic_physical_tag}, 32'd0);
    check("rst_busy",       {31'b0, busy}, 32'd0);
    check("rst_fill_done",  {31'b0, fill_done}, 32'd0);
    check("rst_dirty",      {31'b0, ic_dirty_data}, 32'd0);
    rst = 1'b0;
    step();
    clear_log();

    // Basic fill; abort held during DONE is ignored
    issue_miss(32'h0000_00C4, 24'hABCDEF);
    check("basic_req_valid",  {31'b0, mem_req_valid}, 32'd1);
    check("basic_req_addr",   mem_req_addr, 32'hABCD_EFC0);
    check("basic_miss_ready", {31'b0, miss_ready}, 32'd0);
    check("basic_busy",       {31'b0, busy}, 32'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("basic_req_drop", {31'b0, mem_req_valid}, 32'd0);
    for (int n = 0; n < 16; n++) beat(32'h1000 + 32'(n));
    check("basic_last_va",     ic_va, 32'h0000_00FC);
    check("basic_last_vld",    {31'b0, ic_valid_data}, 32'd1);
    check("basic_tag_we",      {31'b0, ic_tag_write_enable}, 32'd1);
    check("basic_ptag",        {8'b0, ic_physical_tag}, 32'h00AB_CDEF);
    check("basic_done_early",  {31'b0, fill_done}, 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("basic_fill_done",   {31'b0, fill_done}, 32'd1);
    check_idle_outputs("basic_after");
    step();
    check("basic_done_pulse",  {31'b0, fill_done}, 32'd0);
    check("basic_wr_cnt",   32'(wr_cnt), 32'd16);
    check("basic_tag_cnt",  32'(tag_cnt), 32'd1);
    check("basic_done_cnt", 32'(done_cnt), 32'd1);
    check("basic_hs_cnt",   32'(hs_cnt), 32'd1);
    check_writes("basic", 16, 32'h0000_00C0, 32'h1000, 1'b1);
    clear_log();

    // Gapped beats, request held off for 5 cycles
    issue_miss(32'h0000_0040, 24'h123456);
    for (int i = 0; i < 5; i++) begin
      check("gap_req_valid", {31'b0, mem_req_valid}, 32'd1);
      check("gap_req_addr",  mem_req_addr, 32'h1234_5640);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int n = 0; n < 16; n++) begin
      beat(32'hA000_0000 + 32'(n));
      step();
    end
    step();
    check("gap_wr_cnt",   32'(wr_cnt), 32'd16);
    check("gap_tag_cnt",  32'(tag_cnt), 32'd1);
    check("gap_done_cnt", 32'(done_cnt), 32'd1);
    check("gap_hs_cnt",   32'(hs_cnt), 32'd1);
    check_writes("gap", 16, 32'h0000_0040, 32'hA000_0000, 1'b1);
    check_idle_outputs("gap_after");
    clear_log();

    // Abort in REQ before mem_req_ready
    issue_miss(32'h0000_0000, 24'h555555);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle_outputs("reqab");
    step();
    check("reqab_hs_cnt", 32'(hs_cnt), 32'd0);
    check("reqab_wr_cnt", 32'(wr_cnt), 32'd0);
    clear_log();

    // Abort mid-fill: beats 0..6 written, beat 7 arrives with abort
    issue_miss(32'h0000_0080, 24'h0F0F0F);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int n = 0; n < 7; n++) beat(32'hB000 + 32'(n));
    abort = 1'b1;
    beat(32'hB007);
    abort = 1'b0;
    check("midab_we_stop", {31'b0, ic_write_enable}, 32'd0);
    for (int n = 8; n < 15; n++) beat(32'hB000 + 32'(n));
    check("midab_busy_drain", {31'b0, busy}, 32'd1);
    check("midab_ready_drain", {31'b0, miss_ready}, 32'd0);
    beat(32'hB00F);
    check_idle_outputs("midab_end");
    step();
    check("midab_wr_cnt",   32'(wr_cnt), 32'd7);
    check("midab_tag_cnt",  32'(tag_cnt), 32'd0);
    check("midab_done_cnt", 32'(done_cnt), 32'd0);
    check_writes("midab", 7, 32'h0000_0080, 32'hB000, 1'b0);
    clear_log();

    // Abort coinciding with beat 15
    issue_miss(32'h0000_00C0, 24'h777777);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int n = 0; n < 15; n++) beat(32'hC000 + 32'(n));
    abort = 1'b1;
    beat(32'hC00F);
    abort = 1'b0;
    check("lastab_tag_we", {31'b0, ic_tag_write_enable}, 32'd0);
    check_idle_outputs("lastab");
    step();
    check("lastab_fill_done", {31'b0, fill_done}, 32'd0);
    check("lastab_wr_cnt",   32'(wr_cnt), 32'd15);
    check("lastab_tag_cnt",  32'(tag_cnt), 32'd0);
    check("lastab_done_cnt", 32'(done_cnt), 32'd0);
    clear_log();

    // Reset asserted asynchronously just after beat 9 is captured
    issue_miss(32'h0000_0040, 24'h999999);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int n = 0; n < 9; n++) beat(32'hD000 + 32'(n));
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hD009;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    mem_resp_valid = 1'b0;
    check("rstmid_we",         {31'b0, ic_write_enable}, 32'd0);
    check("rstmid_va",         ic_va, 32'd0);
    check("rstmid_wdata",      ic_write_data, 32'd0);
    check("rstmid_ptag",       {8'b0, ic_physical_tag}, 32'd0);
    check("rstmid_req_addr",   mem_req_addr, 32'd0);
    check("rstmid_busy",       {31'b0, busy}, 32'd0);
    check("rstmid_miss_ready", {31'b0, miss_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();
    issue_miss(32'h0000_0080, 24'h246810);
    check("rstmid_new_busy", {31'b0, busy}, 32'd1);
    check("rstmid_new_addr", mem_req_addr, 32'h2468_1080);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle_outputs("rstmid_new_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
